// File: rtl/ekf_uart_pkg.sv
// rtl/ekf_uart_pkg.sv - shared constants, FSM states and packet byte helper for the EKF UART streamer
package ekf_uart_pkg;

  localparam logic [7:0] PKT_HDR   = 8'hA5;
  localparam int         PKT_BYTES = 9;
  localparam int         ENTRY_W   = 49;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Entry layout is {mode, soc[23:0], vrc[23:0]}; the last packet byte is the XOR of the rest.
  function automatic logic [7:0] pkt_byte(input logic [ENTRY_W-1:0] entry, input logic [3:0] idx);
    logic [7:0] mode_b;
    logic [7:0] sum;
    mode_b = {7'b0, entry[48]};
    sum = PKT_HDR ^ mode_b ^ entry[47:40] ^ entry[39:32] ^ entry[31:24]
        ^ entry[23:16] ^ entry[15:8] ^ entry[7:0];
    case (idx)
      4'd0:    pkt_byte = PKT_HDR;
      4'd1:    pkt_byte = mode_b;
      4'd2:    pkt_byte = entry[47:40];
      4'd3:    pkt_byte = entry[39:32];
      4'd4:    pkt_byte = entry[31:24];
      4'd5:    pkt_byte = entry[23:16];
      4'd6:    pkt_byte = entry[15:8];
      4'd7:    pkt_byte = entry[7:0];
      default: pkt_byte = sum;
    endcase
  endfunction

endpackage

// File: rtl/ekf_result_fifo.sv
// rtl/ekf_result_fifo.sv - synchronous result FIFO with full/empty flags and same-cycle push/pop
module ekf_result_fifo
  import ekf_uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] rdata,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [AW:0]        count_q;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ekf_uart_tx.sv
// rtl/ekf_uart_tx.sv - captures EKF results into a FIFO and streams 9-byte framed packets over 8N1 UART
module ekf_uart_tx
  import ekf_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ekf_done,
  input  logic [23:0] ekf_soc,
  input  logic [23:0] ekf_vrc,
  input  logic        mode,
  output logic        tx,
  output logic        busy,
  output logic        overflow
);

  localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_e          state_q, state_d;
  logic               done_q;
  logic               capture;
  logic [BAUD_W-1:0]  baud_q;
  logic [2:0]         bit_idx_q;
  logic [3:0]         byte_idx_q;
  logic [ENTRY_W-1:0] pkt_q;
  logic               tx_q, tx_d;
  logic               ovf_q;
  logic               pop;
  logic               baud_done;
  logic               last_byte;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [7:0]         cur_byte;

  assign capture   = ekf_done & ~done_q;
  assign baud_done = (baud_q == BAUD_LAST);
  assign last_byte = (byte_idx_q == 4'(PKT_BYTES - 1));
  assign cur_byte  = pkt_byte(pkt_q, byte_idx_q);

  ekf_result_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (capture),
    .pop  (pop),
    .wdata({mode, ekf_soc, ekf_vrc}),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!fifo_empty) state_d = START;
      START: if (baud_done) state_d = DATA;
      DATA:  if (baud_done && bit_idx_q == 3'd7) state_d = STOP;
      STOP: begin
        // Chain straight into the next queued packet so packets stay contiguous.
        if (baud_done) state_d = (!last_byte || !fifo_empty) ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop  = 1'b0;
    tx_d = 1'b1;
    unique case (state_q)
      IDLE:    pop  = ~fifo_empty;
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_idx_q];
      STOP:    pop  = baud_done & last_byte & ~fifo_empty;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q     <= 1'b0;
      tx_q       <= 1'b1;
      ovf_q      <= 1'b0;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      pkt_q      <= '0;
    end else begin
      done_q <= ekf_done;
      tx_q   <= tx_d;
      if (capture && fifo_full && !pop) ovf_q <= 1'b1;
      baud_q <= (state_q == IDLE || baud_done) ? '0 : baud_q + 1'b1;
      if (state_q == START)                 bit_idx_q <= '0;
      else if (state_q == DATA && baud_done) bit_idx_q <= bit_idx_q + 1'b1;
      if (pop) begin
        pkt_q      <= fifo_rdata;
        byte_idx_q <= '0;
      end else if (state_q == STOP && baud_done && !last_byte) begin
        byte_idx_q <= byte_idx_q + 1'b1;
      end
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE) | ~fifo_empty;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ekf_uart_tx.sv
// tb/tb_ekf_uart_tx.sv - randomized self-checking bench for ekf_uart_tx against a packet-level timing model
module tb_ekf_uart_tx;

  localparam int CPB     = 4;
  localparam int DEPTH   = 4;
  localparam int PKT_CYC = 90 * CPB;

  logic        clk = 1'b0;
  logic        rst;
  logic        ekf_done;
  logic [23:0] ekf_soc;
  logic [23:0] ekf_vrc;
  logic        mode;
  logic        tx;
  logic        busy;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [48:0] m_ent[$];
  int          m_pops[$];
  bit          m_ovf;
  logic [7:0]  rx_b[$];
  int          rx_t[$];

  ekf_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ekf_done(ekf_done),
    .ekf_soc (ekf_soc),
    .ekf_vrc (ekf_vrc),
    .mode    (mode),
    .tx      (tx),
    .busy    (busy),
    .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART receiver: samples mid-bit on negedges and logs each byte with its start cycle.
  always begin : rx_mon
    int         st;
    logic [7:0] b;
    @(negedge clk);
    if (tx === 1'b0) begin
      st = cyc;
      repeat (CPB / 2) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clk);
        b[k] = tx;
      end
      repeat (CPB) @(negedge clk);
      chk("stop_bit", tx, 1'b1);
      rx_b.push_back(b);
      rx_t.push_back(st);
    end
  end

  function automatic logic [7:0] exp_byte(input logic [48:0] e, input int k);
    logic [7:0] p [9];
    logic [7:0] x;
    p[0] = 8'hA5;
    p[1] = {7'b0, e[48]};
    p[2] = e[47:40];
    p[3] = e[39:32];
    p[4] = e[31:24];
    p[5] = e[23:16];
    p[6] = e[15:8];
    p[7] = e[7:0];
    x = 8'h00;
    for (int i = 0; i < 8; i++) x = x ^ p[i];
    p[8] = x;
    return p[k];
  endfunction

  // Each accepted entry leaves the FIFO one cycle after capture or when the previous packet ends.
  task automatic model_capture(input int t, input logic [48:0] e);
    int occ;
    int p;
    occ = 0;
    foreach (m_pops[i]) if (m_pops[i] > t) occ++;
    if (occ < DEPTH) begin
      p = t + 1;
      if (m_pops.size() > 0 && m_pops[$] + PKT_CYC > p) p = m_pops[$] + PKT_CYC;
      m_pops.push_back(p);
      m_ent.push_back(e);
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic model_clear();
    m_ent.delete();
    m_pops.delete();
    m_ovf = 1'b0;
    rx_b.delete();
    rx_t.delete();
  endtask

  task automatic do_capture(input logic md, input logic [23:0] s, input logic [23:0] v, input int hold);
    ekf_done = 1'b1;
    mode     = md;
    ekf_soc  = s;
    ekf_vrc  = v;
    model_capture(cyc + 1, {md, s, v});
    repeat (hold) @(negedge clk);
    ekf_done = 1'b0;
    mode     = 1'($urandom);
    ekf_soc  = 24'($urandom);
    ekf_vrc  = 24'($urandom);
  endtask

  task automatic capture_at(input int target);
    while (cyc + 1 < target) @(negedge clk);
    do_capture(1'($urandom), 24'($urandom), 24'($urandom), 1);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic wait_idle(input int budget, output int fall_cyc);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    fall_cyc = cyc;
    if (busy !== 1'b0) chk("idle_timeout", busy, 1'b0);
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic verify(input string tag);
    int bad_gap;
    chk($sformatf("%s_nbytes", tag), rx_b.size(), m_ent.size() * 9);
    for (int p = 0; p < m_ent.size(); p++) begin
      if (p * 9 < rx_t.size())
        chk($sformatf("%s_pkt%0d_start", tag, p), rx_t[p * 9], m_pops[p] + 1);
      for (int k = 0; k < 9; k++)
        if (p * 9 + k < rx_b.size())
          chk($sformatf("%s_pkt%0d_b%0d", tag, p, k), rx_b[p * 9 + k], exp_byte(m_ent[p], k));
    end
    bad_gap = 0;
    for (int i = 1; i < rx_t.size(); i++)
      if (i % 9 != 0 && rx_t[i] - rx_t[i - 1] != 10 * CPB) bad_gap++;
    chk($sformatf("%s_byte_gaps", tag), bad_gap, 0);
    chk($sformatf("%s_overflow", tag), overflow, m_ovf);
    rx_b.delete();
    rx_t.delete();
  endtask

  initial begin
    #(80000 * 10);
    $display("FAIL watchdog: simulation did not finish within 80000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int         fall;
    int         cap;
    int         t0;
    int         s;
    int         zeros;
    int         n;
    logic [7:0] lit [9];

    rst      = 1'b1;
    ekf_done = 1'b0;
    mode     = 1'b0;
    ekf_soc  = '0;
    ekf_vrc  = '0;
    m_ovf    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_tx", tx, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_overflow", overflow, 1'b0);

    // Single directed result.
    reset_dut();
    lit = '{8'hA5, 8'h01, 8'h32, 8'h00, 8'h00, 8'h00, 8'h01, 8'h23, 8'hB4};
    cap = cyc + 1;
    do_capture(1'b1, 24'h320000, 24'h000123, 1);
    wait_idle(2000, fall);
    chk("t1_busy_fall", fall, m_pops[0] + PKT_CYC);
    if (rx_t.size() > 0) chk("t1_start_latency", rx_t[0] - cap, 2);
    for (int k = 0; k < 9; k++)
      if (k < rx_b.size()) chk($sformatf("t1_literal_b%0d", k), rx_b[k], lit[k]);
    verify("t1");

    // Held done.
    reset_dut();
    do_capture(1'($urandom), 24'($urandom), 24'($urandom), 1000);
    wait_idle(2000, fall);
    verify("t2");

    // Back-to-back captures.
    reset_dut();
    t0 = cyc + 2;
    for (int i = 0; i < 3; i++) capture_at(t0 + 10 * i);
    wait_idle(3000, fall);
    verify("t3");

    // Overflow: six captures three cycles apart.
    reset_dut();
    t0 = cyc + 2;
    for (int i = 0; i < 6; i++) capture_at(t0 + 3 * i);
    wait_idle(4000, fall);
    verify("t4");
    repeat (100) @(negedge clk);
    chk("t4_overflow_sticky", overflow, 1'b1);
    reset_dut();
    chk("t4_overflow_cleared", overflow, 1'b0);

    // Reset in the middle of byte 3.
    reset_dut();
    cap = cyc + 1;
    do_capture(1'($urandom), 24'($urandom), 24'($urandom), 1);
    s = cap + 2;
    while (cyc < s + 33 * CPB) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_tx_after_rst", tx, 1'b1);
    chk("t5_busy_after_rst", busy, 1'b0);
    rst   = 1'b0;
    zeros = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) zeros++;
    end
    chk("t5_quiet_after_rst", zeros, 0);
    model_clear();
    do_capture(1'($urandom), 24'($urandom), 24'($urandom), 1);
    wait_idle(2000, fall);
    verify("t5");

    // Capture exactly when a full FIFO pops.
    reset_dut();
    t0 = cyc + 2;
    for (int i = 0; i < 5; i++) capture_at(t0 + 2 * i);
    capture_at(t0 + 1 + PKT_CYC);
    wait_idle(4000, fall);
    verify("t6");

    // Random bursts.
    for (int r = 0; r < 4; r++) begin
      reset_dut();
      n  = $urandom_range(1, 7);
      t0 = cyc + 2;
      for (int i = 0; i < n; i++) begin
        capture_at(t0);
        t0 = t0 + $urandom_range(2, 200);
      end
      wait_idle(6000, fall);
      verify($sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
